// File: rtl/ezrisc_mem_pkg.sv
// Shared encodings for the memory controller: FSM states and the latched
// operation type.
package ezrisc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/ram_sync.sv
// Single-port synchronous word RAM.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data (old contents on a same-cycle write)
// INIT_FILE names a hex preload image. Loading it is left to the memory
// macro / technology flow; this model does not load the image itself.
module ram_sync #(
    parameter int    REG_SIZE  = 32,
    parameter int    ADDR_BITS = 9,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [REG_SIZE-1:0]  wdata,
    output logic [REG_SIZE-1:0]  rdata
);

    localparam bit unused_init = (INIT_FILE != "");

    logic [REG_SIZE-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller with wait-state insertion in front of an on-chip RAM.
// A request is latched in IDLE, optionally delayed WAIT_STATES cycles, the
// RAM is accessed for one cycle, and DONE raises a one-cycle mem_ready.
// Ports:
//   clk, reset_n            clock / async active-low reset
//   mem_read, mem_write     request strobes (write wins if both)
//   mar_out, mdr_output     address / write data, latched on accept
//   m_data_in               registered read data
//   mem_ready, mem_busy     completion pulse / transaction in flight
//   mem_err                 out-of-range address flag (DONE cycle only)
// Optional feature macro: MEM_BOUNDS_CHECK_EN. When it is undefined, the
// upper address bits alias and mem_err is always 0.
module mem_ctrl
    import ezrisc_mem_pkg::*;
#(
    parameter int    REG_SIZE    = 32,
    parameter int    ADDR_BITS   = 9,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [REG_SIZE-1:0] mar_out,
    input  logic [REG_SIZE-1:0] mdr_output,
    output logic [REG_SIZE-1:0] m_data_in,
    output logic                mem_ready,
    output logic                mem_busy,
    output logic                mem_err
);

    // Counter holds at most WAIT_STATES-1.
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [REG_SIZE-1:0]   data_q, data_d;
    op_e                   op_q, op_d;
    logic                  oob_q, oob_d;
    logic [REG_SIZE-1:0]   mdi_q, mdi_d;

    logic                  oob_in;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [REG_SIZE-1:0]   ram_rdata;

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob_in = |mar_out[REG_SIZE-1:ADDR_BITS];
`else
    logic unused_hi;
    assign unused_hi = |mar_out[REG_SIZE-1:ADDR_BITS];
    assign oob_in    = 1'b0;
`endif

    // In IDLE the RAM is addressed straight from mar_out so that, with zero
    // wait states, rdata already holds RAM[addr] during ACCESS. Nothing else
    // writes the RAM while a transaction is in flight, so that value is current.
    assign ram_addr = (state_q == IDLE) ? mar_out[ADDR_BITS-1:0] : addr_q;
    assign ram_we   = (state_q == ACCESS) && (op_q == OP_WR) && !oob_q;

    ram_sync #(
        .REG_SIZE  (REG_SIZE),
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        oob_d   = oob_q;
        mdi_d   = mdi_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = mar_out[ADDR_BITS-1:0];
                    data_d  = mdr_output;
                    op_d    = mem_write ? OP_WR : OP_RD;
                    oob_d   = oob_in;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ACCESS: begin
                state_d = DONE;
                if (op_q == OP_RD) mdi_d = oob_q ? '0 : ram_rdata;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= OP_RD;
            oob_q   <= 1'b0;
            mdi_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            oob_q   <= oob_d;
            mdi_q   <= mdi_d;
        end
    end

    assign m_data_in = mdi_q;
    assign mem_ready = (state_q == DONE);
    assign mem_busy  = (state_q != IDLE);
    assign mem_err   = (state_q == DONE) && oob_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl. Two instances share a clock
// and reset: index 0 uses two wait states, index 1 uses none. A per-instance
// word array models RAM contents and the last read value.
module tb_mem_ctrl;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    localparam int WS [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_s  [2];
    logic        wr_s  [2];
    logic [31:0] mar   [2];
    logic [31:0] mdr   [2];
    logic [31:0] mdi   [2];
    logic        rdy   [2];
    logic        busy  [2];
    logic        err   [2];

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl     [2][512];
    bit          vld     [2][512];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    mem_ctrl #(.REG_SIZE(32), .ADDR_BITS(9), .WAIT_STATES(2), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset_n(reset_n), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
        .mar_out(mar[0]), .mdr_output(mdr[0]), .m_data_in(mdi[0]),
        .mem_ready(rdy[0]), .mem_busy(busy[0]), .mem_err(err[0]));

    mem_ctrl #(.REG_SIZE(32), .ADDR_BITS(9), .WAIT_STATES(0), .INIT_FILE("")) u_dut1 (
        .clk(clk), .reset_n(reset_n), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
        .mar_out(mar[1]), .mdr_output(mdr[1]), .m_data_in(mdi[1]),
        .mem_ready(rdy[1]), .mem_busy(busy[1]), .mem_err(err[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_mdi"},   mdi[d],  32'h0);
            chk({tag, "_ready"}, 32'(rdy[d]),  32'h0);
            chk({tag, "_busy"},  32'(busy[d]), 32'h0);
            chk({tag, "_err"},   32'(err[d]),  32'h0);
        end
    endtask

    // One full transaction, entered and left at a negedge with the DUT idle.
    task automatic txn(input int d, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] dat, input bit garble);
        int lat = 0;
        int busy_n = 0;
        bit got_rdy = 0;
        bit oob;
        int idx;
        logic [31:0] exp_rd;
        idx = int'(a[8:0]);
        oob = BC && (a[31:9] != 0);
        mar[d] = a; mdr[d] = dat; wr_s[d] = w; rd_s[d] = r;
        @(posedge clk);
        while (lat < 20) begin
            @(negedge clk);
            if (busy[d]) busy_n++;
            if (rdy[d]) begin
                got_rdy = 1;
                break;
            end
            if (garble) begin
                mar[d] = $urandom; mdr[d] = $urandom;
                wr_s[d] = 1'($urandom); rd_s[d] = 1'($urandom);
            end else begin
                wr_s[d] = 0; rd_s[d] = 0;
            end
            @(posedge clk);
            lat++;
        end
        wr_s[d] = 0; rd_s[d] = 0;
        chk("ready_seen", 32'(got_rdy), 32'h1);
        if (got_rdy) begin
            chk("latency", 32'(lat), 32'(WS[d] + 1));
            chk("busy_cycles", 32'(busy_n), 32'(WS[d] + 2));
            chk("err", 32'(err[d]), 32'(oob));
            if (w) begin
                if (!oob) begin
                    mdl[d][idx] = dat;
                    vld[d][idx] = 1;
                end
                chk("hold_rdata", mdi[d], last_rd[d]);
            end else begin
                exp_rd = oob ? 32'h0 : mdl[d][idx];
                chk("rdata", mdi[d], exp_rd);
                last_rd[d] = exp_rd;
            end
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy[d]), 32'h0);
        chk("ready_pulse", 32'(rdy[d]), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int op;
        for (int d = 0; d < 2; d++) begin
            rd_s[d] = 0; wr_s[d] = 0; mar[d] = 0; mdr[d] = 0; last_rd[d] = 0;
            for (int i = 0; i < 512; i++) vld[d][i] = 0;
        end

        // Reset with random inputs: outputs stay zero.
        reset_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rd_s[d] = 1'($urandom); wr_s[d] = 1'($urandom);
                mar[d] = $urandom; mdr[d] = $urandom;
            end
        end
        chk_outputs_zero("rst");
        for (int d = 0; d < 2; d++) begin
            rd_s[d] = 0; wr_s[d] = 0;
        end
        reset_n = 1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("post_rst");

        // Directed: two wait states, write then read back.
        txn(0, 1, 0, 32'd5, 32'hDEADBEEF, 0);
        txn(0, 0, 1, 32'd5, 32'h0, 0);
        chk("rd5", last_rd[0], 32'hDEADBEEF);

        // Directed: zero wait states, both strobes high -> write.
        txn(1, 1, 1, 32'd7, 32'h12345678, 0);
        txn(1, 0, 1, 32'd7, 32'h0, 0);
        chk("rd7", last_rd[1], 32'h12345678);

        // Preload a window so every later read hits known contents.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) txn(d, 1, 0, 32'(i), $urandom, 0);

        // Inputs churn while busy: only the latched data lands.
        txn(0, 1, 0, 32'd3, 32'h11112222, 1);
        txn(0, 0, 1, 32'd3, 32'h0, 1);
        chk("rd3_latched", last_rd[0], 32'h11112222);

        // Abort a write in WAIT with reset: no write, no mem_ready.
        mar[0] = 32'd3; mdr[0] = 32'h55; wr_s[0] = 1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_wait", 32'(busy[0]), 32'h1);
        reset_n = 0;
        wr_s[0] = 0;
        #1;
        chk_outputs_zero("abort_rst");
        last_rd[0] = 0; last_rd[1] = 0;
        @(negedge clk);
        reset_n = 1;
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (rdy[0]) seen++;
            end
            chk("abort_no_ready", 32'(seen), 32'h0);
        end
        txn(0, 0, 1, 32'd3, 32'h0, 0);
        chk("rd3_after_abort", last_rd[0], 32'h11112222);

        // Upper-bit address: alias or bounds error depending on build.
        txn(0, 1, 0, 32'h0, 32'h77, 0);
        txn(0, 1, 0, 32'h200, 32'hA5, 0);
        txn(0, 0, 1, 32'h0, 32'h0, 0);
        chk("alias_addr0", last_rd[0], BC ? 32'h77 : 32'hA5);
        txn(0, 0, 1, 32'h200, 32'h0, 0);

        // Random traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            int d = n % 2;
            if ($urandom_range(0, 7) == 0)
                a = {23'($urandom_range(1, 3)), 9'($urandom_range(0, 15))};
            else
                a = 32'($urandom_range(0, 15));
            op = $urandom_range(0, 2);
            if (op != 1 || !vld[d][a[8:0]] && !(BC && a[31:9] != 0))
                txn(d, 1, op == 2, a, $urandom, $urandom_range(0, 1) == 1);
            else
                txn(d, 0, 1, a, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
